// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding, field sizes and byte packing for the image loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CHECK, DONE, ERROR} loader_state_t;
  localparam int HDR_BYTES = 4;
  localparam int CSUM_BYTES = 4;
  function automatic logic [31:0] le_pack(input logic [7:0] b [4]);
    return {b[3], b[2], b[1], b[0]};
  endfunction
endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: gathers four accepted bytes little-endian and flags the completed word
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);
  localparam int FIELD_BYTES = (HDR_BYTES > CSUM_BYTES) ? HDR_BYTES : CSUM_BYTES;
  logic [7:0] field [4];
  logic [7:0] field_n [4];
  logic [1:0] cnt;
  // current byte merged into the partial field so the word is complete in the cycle of its last byte
  always_comb begin
    field_n = field;
    field_n[cnt] = data;
  end
  assign word_valid = accept && cnt == 2'(FIELD_BYTES - 1);
  assign word = le_pack(field_n);
  // byte position wraps naturally after the last byte of each field
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      field <= '{default: 8'h00};
    end else if (clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 2'd1;
      field[cnt] <= data;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a checksummed program image into instruction RAM and releases the core
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  loader_state_t state, state_n;
  logic [31:0] n, sum, word;
  logic [ADDR_W:0] k;
  logic accept, word_valid, pay_word, last_word;
  assign rx_ready = !load_req && (state == HEADER || state == PAYLOAD || state == CHECK);
  assign accept = rx_valid && rx_ready;
  assign pay_word = word_valid && state == PAYLOAD;
  assign last_word = 32'(k) + 32'd1 == n;
  byte_assembler u_asm (
    .clk(clk),
    .rst(reset),
    .clr(load_req),
    .accept(accept),
    .data(rx_data),
    .word_valid(word_valid),
    .word(word)
  );
  // field completion drives every transition; load_req restarts from any state
  always_comb begin
    state_n = state;
    if (load_req) state_n = HEADER;
    else if (word_valid)
      state_n = state == HEADER  ? (word > 32'(DEPTH) ? ERROR : word == 32'd0 ? CHECK : PAYLOAD)
              : state == PAYLOAD ? (last_word ? CHECK : PAYLOAD)
              : state == CHECK   ? (word == sum ? DONE : ERROR)
              : state;
  end
  // state, counters, checksum and registered outputs; a write issued before load_req still lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      n <= '0;
      k <= '0;
      sum <= '0;
      we <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done <= 1'b0;
      error <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state <= state_n;
      we <= pay_word;
      if (pay_word) begin
        waddr <= k[ADDR_W-1:0];
        wdata <= word;
      end
      done <= state_n == DONE;
      error <= state_n == ERROR;
      cpu_hold <= state_n != DONE;
      if (load_req) begin
        n <= '0;
        k <= '0;
        sum <= '0;
      end else if (word_valid && state == HEADER) begin
        n <= word;
      end else if (pay_word) begin
        k <= k + 1'b1;
        sum <= sum + word;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized image loads checked against a stream-level reference model
module tb_imem_loader;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic reset, load_req, rx_valid;
  logic [7:0] rx_data;
  logic rx_ready, we, cpu_hold, done, error;
  logic [AW-1:0] waddr;
  logic [31:0] wdata;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] stream [$];
  logic [AW+31:0] exp_w [$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  // every observed RAM write must match the next write the model predicted
  always @(negedge clk) begin
    if (reset === 1'b0 && we === 1'b1) begin
      vectors++;
      if (exp_w.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got waddr=%0d wdata=%h, required no write", waddr, wdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_w.pop_front();
        if ({waddr, wdata} !== e) begin
          miscompares++;
          $display("FAIL write: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                   waddr, wdata, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] le_at(int i);
    return {stream[i+3], stream[i+2], stream[i+1], stream[i]};
  endfunction

  function automatic void push_word(logic [31:0] w);
    for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
  endfunction

  // reference: decode the whole stream, queue expected writes, return whether it should be accepted
  task automatic model(output bit ok);
    logic [31:0] nw, s;
    nw = le_at(0);
    s = 32'd0;
    ok = 1'b0;
    if (nw > DEPTH) return;
    for (int k = 0; k < int'(nw); k++) begin
      s += le_at(4 + 4 * k);
      exp_w.push_back({AW'(k), le_at(4 + 4 * k)});
    end
    ok = le_at(4 + 4 * int'(nw)) == s;
  endtask

  task automatic build_random(int nw, bit corrupt);
    logic [31:0] s, w;
    s = 32'd0;
    stream.delete();
    push_word(32'(nw));
    for (int k = 0; k < nw; k++) begin
      w = $urandom;
      s += w;
      push_word(w);
    end
    push_word(corrupt ? s ^ (32'd1 << $urandom_range(0, 31)) : s);
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = b;
      #1;
      acc = rx_ready;
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL byte_accept: got rx_ready=0 for 20 cycles, required 1");
    end
  endtask

  task automatic send_range(int first, int last, bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(stream[i]);
    end
  endtask

  task automatic check_result(string name, bit ok);
    @(negedge clk);
    #1;
    vectors++;
    if ({done, error, cpu_hold, rx_ready} !== {ok, !ok, !ok, 1'b0}) begin
      miscompares++;
      $display("FAIL %s result: got done=%b error=%b cpu_hold=%b rx_ready=%b, required %b %b %b 0",
               name, done, error, cpu_hold, rx_ready, ok, !ok, !ok);
    end
    vectors++;
    if (exp_w.size() != 0) begin
      miscompares++;
      $display("FAIL %s writes: got %0d missing writes, required 0", name, exp_w.size());
    end
  endtask

  task automatic run_image(string name, bit gaps);
    bit ok;
    model(ok);
    pulse_load();
    send_range(0, stream.size() - 1, gaps);
    check_result(name, ok);
  endtask

  task automatic check_reset_outputs(string name);
    vectors++;
    if ({we, waddr, wdata, rx_ready, cpu_hold, done, error} !== {1'b0, AW'(0), 32'd0, 4'b0100}) begin
      miscompares++;
      $display("FAIL %s: got we=%b waddr=%0d wdata=%h rx_ready=%b cpu_hold=%b done=%b error=%b, required 0 0 0 0 1 0 0",
               name, we, waddr, wdata, rx_ready, cpu_hold, done, error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_basic_image();
    stream.delete();
    push_word(32'd2); push_word(32'h00000013); push_word(32'h00100093); push_word(32'h001000A6);
    run_image("basic_image", 1'b0);
  endtask

  task automatic test_bad_checksum();
    stream.delete();
    push_word(32'd2); push_word(32'h00000013); push_word(32'h00100093); push_word(32'h001000A7);
    run_image("bad_checksum", 1'b0);
  endtask

  task automatic test_oversize();
    stream.delete();
    push_word(32'd1025);
    run_image("oversize", 1'b0);
  endtask

  task automatic test_empty_then_reload();
    stream.delete();
    push_word(32'd0); push_word(32'd0);
    run_image("empty_image", 1'b0);
    pulse_load();
    #1;
    vectors++;
    if ({done, error, cpu_hold, rx_ready} !== 4'b0011) begin
      miscompares++;
      $display("FAIL reload_clears: got done=%b error=%b cpu_hold=%b rx_ready=%b, required 0 0 1 1",
               done, error, cpu_hold, rx_ready);
    end
  endtask

  task automatic test_gaps_and_reset();
    stream.delete();
    push_word(32'd2); push_word(32'h00000013); push_word(32'h00100093); push_word(32'h001000A6);
    run_image("gapped_image", 1'b1);
    build_random(3, 1'b0);
    pulse_load();
    exp_w.push_back({AW'(0), le_at(4)});
    send_range(0, 8, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_load");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("after_mid_load_reset");
    build_random(5, 1'b0);
    run_image("after_reset_image", 1'b1);
  endtask

  task automatic test_restart();
    build_random(2, 1'b0);
    pulse_load();
    send_range(0, 5, 1'b0);
    build_random(4, 1'b0);
    run_image("restart_image", 1'b1);
  endtask

  task automatic test_random_images();
    for (int i = 0; i < 8; i++) begin
      build_random($urandom_range(1, 16), $urandom_range(0, 1) == 1);
      run_image("random_image", 1'b1);
    end
  endtask

  task automatic test_full_depth();
    stream.delete();
    push_word(32'd1024);
    for (int k = 0; k < 1024; k++) push_word(32'(k));
    push_word(32'h0007FE00);
    run_image("full_depth", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_image();
    test_bad_checksum();
    test_oversize();
    test_empty_then_reload();
    test_gaps_and_reset();
    test_restart();
    test_random_images();
    test_full_depth();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream and writes it, word by word, into the instruction RAM write port.
- The core's fetch port reads word k at byte address 4k, i.e. index pc[ADDR_W+1:2].
- Holds the core in reset (cpu_hold) until a complete image with a valid checksum has been loaded.
- Sits between the serial/debug byte source and the instruction RAM.

Parameters:
- DEPTH, 1024, instruction memory depth in 32-bit words.
- ADDR_W, $clog2(DEPTH), word-address width (localparam, derived).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- load_req  input  1  single-cycle pulse that starts or restarts a load.
- rx_valid  input  1  byte available on rx_data.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader accepts the byte; a transfer occurs when rx_valid && rx_ready.
- we  output  1  instruction RAM write enable.
- waddr  output  ADDR_W  word address.
- wdata  output  32  instruction word.
- cpu_hold  output  1  core held in reset.
- done  output  1  image loaded and checksum matched.
- error  output  1  image rejected.

Behaviour:
- Reset values: state IDLE; we=0, waddr=0, wdata=0, rx_ready=0, cpu_hold=1, done=0, error=0. All counters and the checksum accumulator are cleared.
- Reset mid-load: immediate return to the reset values. Words already written stay in RAM. No further writes occur.
- Stream format, all fields little-endian:
  - 4-byte word count N.
  - N×4 payload bytes.
  - 4-byte checksum = sum of all payload words mod 2^32.
- FSM states: IDLE, HEADER, PAYLOAD, CHECK, DONE, ERROR.
  - IDLE: rx_ready=0, cpu_hold=1. load_req moves to HEADER.
  - HEADER: rx_ready=1. Collects 4 bytes into N.
    - On the 4th byte: N>DEPTH goes to ERROR; N==0 goes to CHECK; otherwise goes to PAYLOAD.
  - PAYLOAD: rx_ready=1. Byte index b (0..3) and word index k (0..N-1).
    - Byte i of a word lands in wdata[8i+7:8i].
    - When the 4th byte is accepted in cycle t: in cycle t+1 we=1 for exactly one cycle, waddr=k, wdata=assembled word, and sum += word.
    - After word N-1 is accepted, go to CHECK.
    - No back-pressure is needed; a new byte may be accepted in t+1.
  - CHECK: rx_ready=1. Collects 4 bytes.
    - On the 4th byte, the next state is DONE if it equals sum, else ERROR.
  - DONE: rx_ready=0, cpu_hold=0, done=1.
  - ERROR: rx_ready=0, cpu_hold=1, error=1.
- load_req in any state (including mid-load):
  - Next cycle enter HEADER.
  - Clear b, k, N and sum; clear done and error; cpu_hold=1.
  - A write already scheduled for this cycle still completes.
- Gaps: bytes with rx_valid=0 are ignored. Any number of idle cycles between bytes is legal.
- Counters:
  - k is ADDR_W+1 bits, so N=DEPTH is legal. The last waddr is DEPTH-1 and waddr never wraps.
  - N is held in full 32 bits for the range check.
- Outputs we/waddr/wdata/done/error/cpu_hold are all registered.

Decomposition:
- Package imem_loader_pkg:
  - State enum loader_state_t.
  - Localparams HDR_BYTES=4 and CSUM_BYTES=4.
  - A function le_pack(byte array) returning a 32-bit word.
- One sub-module, byte_assembler:
  - Shifts in accepted bytes little-endian.
  - Pulses word_valid with the 32-bit word on the 4th byte.
  - Reused for header, payload and checksum fields; cleared by the FSM.

Test Plan:
1. load_req; bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | A6 00 10 00 -> we pulses with (waddr 0, wdata 0x00000013) then (waddr 1, wdata 0x00100093), each one cycle after the 4th byte; then done=1, cpu_hold=0, rx_ready=0.
2. Same image with checksum A7 00 10 00 -> both writes occur; error=1, done=0, cpu_hold=1.
3. Header 01 04 00 00 (N=1025, DEPTH=1024) -> ERROR after the 4th header byte; no we pulse; rx_ready=0.
4. Header 00 00 00 00 then checksum 00 00 00 00 -> done=1, no writes. Then load_req -> done=0, cpu_hold=1, state HEADER.
5. Test 1 image with random rx_valid gaps -> identical writes and result. Reset asserted after 5 payload bytes -> every output at its reset value that cycle; a subsequent load_req plus full image completes normally.
6. N=1024 with word k = k, checksum 0x0007FE00 (bytes 00 FE 07 00) -> 1024 writes, last waddr=1023 with no wrap, done=1.
